// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-control bus: redirect sources from D/M stages and fetch-side outputs.
// The master drives the pipeline inputs and the slave is the fetch controller.
interface pc_fetch_ctrl_if;
    logic        stallF;
    logic        pred_takeD;
    logic [31:0] branch_targetD;
    logic        branchM;
    logic        pred_takeM;
    logic        actual_takeM;
    logic [31:0] branch_targetM;
    logic [31:0] pcM;
    logic        exceptM;
    logic [31:0] pcF;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic        flushD;
    logic        flushE;
    logic        pc_adelF;
    logic        mispredM;

    modport master (
        output stallF, pred_takeD, branch_targetD, branchM, pred_takeM, actual_takeM,
               branch_targetM, pcM, exceptM,
        input  pcF, inst_sram_en, inst_sram_addr, flushD, flushE, pc_adelF, mispredM
    );

    modport slave (
        input  stallF, pred_takeD, branch_targetD, branchM, pred_takeM, actual_takeM,
               branch_targetM, pcM, exceptM,
        output pcF, inst_sram_en, inst_sram_addr, flushD, flushE, pc_adelF, mispredM
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC generator: next-PC priority mux plus a two-state FSM that parks
// exception/mispredict redirects arriving while fetch is stalled.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter logic [31:0] EXC_VEC  = 32'hBFC00380
) (
    input logic             clk,
    input logic             rst,
    pc_fetch_ctrl_if.slave  bus
);

    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_HOLD   = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        pend_exc_q, pend_exc_d;

    logic        mispred;
    logic [31:0] correct_pc;
    logic [31:0] next_pc;

    always_comb begin
        mispred    = bus.branchM & (bus.pred_takeM ^ bus.actual_takeM);
        correct_pc = bus.actual_takeM ? bus.branch_targetM : (bus.pcM + 32'd8);

        if (bus.exceptM) begin
            next_pc = EXC_VEC;
        end else if (mispred) begin
            next_pc = correct_pc;
        end else if (state_q == ST_HOLD) begin
            next_pc = pend_pc_q;
        end else if (bus.pred_takeD) begin
            next_pc = bus.branch_targetD;
        end else begin
            next_pc = pc_q + 32'd4;
        end

        pc_d = bus.stallF ? pc_q : next_pc;
    end

    always_comb begin
        state_d    = state_q;
        pend_pc_d  = pend_pc_q;
        pend_exc_d = pend_exc_q;
        case (state_q)
            ST_NORMAL: begin
                if (bus.stallF && (bus.exceptM || mispred)) begin
                    state_d    = ST_HOLD;
                    pend_pc_d  = bus.exceptM ? EXC_VEC : correct_pc;
                    pend_exc_d = bus.exceptM;
                end
            end
            ST_HOLD: begin
                if (!bus.stallF) begin
                    state_d    = ST_NORMAL;
                    pend_exc_d = 1'b0;
                end else if (bus.exceptM) begin
                    pend_pc_d  = EXC_VEC;
                    pend_exc_d = 1'b1;
                end else if (mispred && !pend_exc_q) begin
                    // A held exception outranks any later mispredict.
                    pend_pc_d = correct_pc;
                end
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_NORMAL;
            pc_q       <= RESET_PC;
            pend_pc_q  <= 32'h0;
            pend_exc_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            pend_exc_q <= pend_exc_d;
        end
    end

    always_comb begin
        bus.pcF            = pc_q;
        bus.inst_sram_addr = pc_q;
        bus.pc_adelF       = (pc_q[1:0] != 2'b00);
        bus.inst_sram_en   = rst & ~bus.pc_adelF;
        bus.mispredM       = mispred;
        // Mispredict keeps the E-stage delay slot; only exceptions kill it.
        bus.flushD         = bus.exceptM | mispred;
        bus.flushE         = bus.exceptM;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- RESET_PC, 32'hBFC00000, fetch address after reset.
- EXC_VEC, 32'hBFC00380, exception entry address.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, rising-edge clock.
- rst, in, 1, reset; asynchronous and active-low (0 = reset).
- stallF, in, 1, hold pcF this cycle.
- pred_takeD, in, 1, D-stage predicted-taken branch (from branch_predict_global).
- branch_targetD, in, 32, D-stage branch target.
- branchM, in, 1, M-stage instruction is a branch.
- pred_takeM, in, 1, prediction carried with the M-stage branch.
- actual_takeM, in, 1, M-stage resolved direction.
- branch_targetM, in, 32, M-stage branch target.
- pcM, in, 32, M-stage branch PC.
- exceptM, in, 1, M-stage exception pulse.
- pcF, out, 32, current fetch PC.
- inst_sram_en, out, 1, instruction-memory request enable.
- inst_sram_addr, out, 32, instruction-memory address.
- flushD, out, 1, flush F/D register.
- flushE, out, 1, flush D/E register.
- pc_adelF, out, 1, pcF misaligned.
- mispredM, out, 1, misprediction detected this cycle.

Function
REQ-003 mispredM SHALL be combinational: branchM & (pred_takeM != actual_takeM).

REQ-004 The correct target on a mispredict SHALL be branch_targetM when actual_takeM=1, else pcM+8 (32-bit add, wraps modulo 2^32).

REQ-005 The next-PC priority SHALL be, highest first:
- exceptM -> EXC_VEC.
- mispredM -> correct target (REQ-004).
- pending redirect held (REQ-007) -> the held address.
- pred_takeD -> branch_targetD.
- otherwise -> pcF+4 (wraps modulo 2^32).

REQ-006 When stallF=0, pcF SHALL load the selected next PC on the rising clk edge; when stallF=1, pcF SHALL hold its value.

REQ-007 A two-state FSM SHALL capture redirects that arrive while fetch is stalled:
- NORMAL: on exceptM or mispredM with stallF=1, latch the target into pend_pc and go to HOLD.
- HOLD: while stallF=1, a new exceptM SHALL overwrite pend_pc; a mispredM SHALL overwrite pend_pc only if no exception target is held.
- HOLD, stallF=0: pcF <= pend_pc and return to NORMAL, unless exceptM or mispredM is asserted in that same cycle, in which case the live event wins (REQ-005).

REQ-008 A pred_takeD arriving while stallF=1 SHALL NOT be captured; the predictor re-presents it while D is stalled.

REQ-009 Flush outputs SHALL be combinational and asserted in the cycle of the event, regardless of stallF:
- flushD = exceptM | mispredM.
- flushE = exceptM.
- The E-stage delay slot SHALL survive a mispredict.

REQ-010 The request outputs SHALL be:
- inst_sram_addr = pcF.
- inst_sram_en = rst & ~pc_adelF.
- pc_adelF = (pcF[1:0] != 2'b00).

REQ-011 pred_takeD redirects the fetch that follows the delay slot: with the branch in D and its delay slot in F, the next pcF is branch_targetD.

REQ-012 exceptM and mispredM in the same cycle SHALL resolve to EXC_VEC, with flushD=1 and flushE=1.

Reset
REQ-013 With rst=0, asynchronously:
- pcF = RESET_PC.
- FSM = NORMAL.
- pend_pc = 0.
- inst_sram_en = 0.

REQ-014 On rst deassertion, the first rising edge SHALL apply REQ-005 to pcF = RESET_PC.

REQ-015 Asserting rst mid-HOLD SHALL discard the held redirect.

Verification
REQ-016 Reset release, stallF=0, no events, 3 cycles -> pcF = BFC00000, BFC00004, BFC00008, BFC0000C.

REQ-017 pred_takeD=1, branch_targetD=BFC00100, with pcF=BFC00008 -> next pcF = BFC00100, flushD=0.

REQ-018 branchM=1, pred_takeM=1, actual_takeM=0, pcM=BFC00040 -> mispredM=1, flushD=1, flushE=0, next pcF = BFC00048.

REQ-019 stallF=1 for 3 cycles, mispredict (actual_takeM=1, branch_targetM=BFC00200) in cycle 1 -> pcF held for 3 cycles, then BFC00200 on the first unstalled edge.

REQ-020 exceptM=1 and mispredM=1 together, with pred_takeD=1 -> next pcF = BFC00380, flushD=1, flushE=1.

REQ-021 Force pcF=BFC00002 (redirect via branch_targetD) -> pc_adelF=1, inst_sram_en=0; rst=0 asynchronously mid-cycle -> pcF = BFC00000 immediately.
